// File: rtl/bcd_countdown_timer_if.sv
// Bundles the control strobes and status outputs of bcd_countdown_timer.
//   master : drives load/load_value/start/pause/tick, observes status.
//   slave  : the timer; consumes controls, drives count/running/expired/
//            expire_pulse/load_err.
interface bcd_countdown_timer_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    start;
  logic                    pause;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    running;
  logic                    expired;
  logic                    expire_pulse;
  logic                    load_err;

  modport master (
    output load, load_value, start, pause, tick,
    input  count, running, expired, expire_pulse, load_err
  );

  modport slave (
    input  load, load_value, start, pause, tick,
    output count, running, expired, expire_pulse, load_err
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD game-clock timer advanced by a one-cycle tick strobe.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - bcd_countdown_timer_if.slave: load/load_value/start/pause/tick in;
//           count/running/expired/expire_pulse/load_err out (all registered)
// Count down to all-zero or up to all-limit; digit 1 limited to 5 in MM:SS
// mode. Control priority: reset > load > pause > start > tick.
module bcd_countdown_timer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned COUNT_UP   = 0,
  parameter int unsigned MMSS       = 1,
  parameter int unsigned WRAP       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_countdown_timer_if.slave  bus
);
  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           expired_q, expired_d;
  logic           pulse_q, pulse_d;
  logic           load_err_q, load_err_d;

  function automatic logic [3:0] lim(input int unsigned i);
    if (MMSS != 0 && i == 1) return 4'd5;
    return 4'd9;
  endfunction

  function automatic logic is_term(input logic [W-1:0] v);
    logic t;
    t = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] != ((COUNT_UP != 0) ? lim(i) : 4'd0)) t = 1'b0;
    return t;
  endfunction

  // Ripple borrow/carry: only the low digit is forced to move; higher digits
  // move only while every digit below them wrapped.
  function automatic logic [W-1:0] step(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         cy;
    logic [3:0]   d;
    r  = v;
    cy = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (cy) begin
        if (COUNT_UP != 0) begin
          if (d == lim(i)) r[4*i +: 4] = 4'd0;
          else begin r[4*i +: 4] = d + 4'd1; cy = 1'b0; end
        end else begin
          if (d == 4'd0) r[4*i +: 4] = lim(i);
          else begin r[4*i +: 4] = d - 4'd1; cy = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] > lim(i)) r[4*i +: 4] = 4'd0;
    return r;
  endfunction

  function automatic logic load_bad(input logic [W-1:0] v);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] > lim(i)) b = 1'b1;
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      expired_q  <= 1'b0;
      pulse_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      expired_q  <= expired_d;
      pulse_q    <= pulse_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    expired_d  = expired_q;
    pulse_d    = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      state_d    = IDLE;
      count_d    = sanitize(bus.load_value);
      reload_d   = count_d;
      expired_d  = 1'b0;
      load_err_d = load_bad(bus.load_value);
    end else if (bus.pause) begin
      // pause also masks a simultaneous start or tick
      if (state_q == RUN) state_d = PAUSED;
    end else if (bus.start) begin
      if (state_q != RUN) begin
        if (state_q == DONE) count_d = reload_q;
        expired_d = 1'b0;
        // starting on an already-terminal value completes immediately
        if (is_term(count_d)) begin
          state_d   = DONE;
          expired_d = 1'b1;
          pulse_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    end else if (bus.tick && state_q == RUN) begin
      if (WRAP != 0 && is_term(count_q)) begin
        count_d = reload_q;
      end else begin
        count_d = step(count_q);
        if (is_term(count_d)) begin
          expired_d = 1'b1;
          pulse_d   = 1'b1;
          if (WRAP == 0) state_d = DONE;
        end
      end
    end
  end

  always_comb begin
    bus.count        = count_q;
    bus.running      = (state_q == RUN);
    bus.expired      = expired_q;
    bus.expire_pulse = pulse_q;
    bus.load_err     = load_err_q;
  end
endmodule
